uart_fifo_ptr_ctrl: RTL and testbench

- Pointer and flag controller for the UART TX/RX byte FIFOs.
- Owns the binary write/read pointers, accepts or rejects push/pop requests, and drives the RAM addresses.
- Produces registered full/empty/almost_full/count flags.
- Exports Gray-coded copies of both pointers. These are produced through bin_to_gray_n and are ready for a later clock-domain split.

---
 rtl/uart_fifo_defs_pkg.sv | 17 +
 rtl/bin_to_gray_n.sv | 14 +
 rtl/uart_fifo_ptr_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_fifo_ptr_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_defs_pkg.sv
// Shared sizing defaults and helpers for the UART TX/RX byte FIFOs.
// Latency: none (compile-time constants and pure functions only).
// Backpressure: not applicable; consumed by the FIFO pointer controllers.
package uart_fifo_defs_pkg;

  // RAM address width; the FIFO holds 2**FIFO_ADDR_W bytes.
  localparam int FIFO_ADDR_W = 4;

  // Occupancy at which almost_full asserts (legal range 1..depth).
  localparam int UART_AF_LEVEL = 12;

  // Number of entries addressed by an addr_w-bit RAM address.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/bin_to_gray_n.sv
// Purely combinational N-bit binary to reflected Gray code converter.
// Latency: zero cycles; the caller registers the result.
// Backpressure: none; output follows input continuously.
module bin_to_gray_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  // Each Gray bit is the XOR of a binary bit and its more significant neighbour.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/uart_fifo_ptr_ctrl.sv
// Write/read pointer and flag controller for a UART byte FIFO with show-ahead reads.
// Latency: accepts are combinational; pointers, flags, count and Gray copies update on the accepting edge.
// Backpressure: pushes refused while full (overflow pulse), pops refused while empty (underflow pulse).
module uart_fifo_ptr_ctrl
  import uart_fifo_defs_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = UART_AF_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_accept,
  output logic              rd_accept,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              overflow,
  output logic              underflow
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the RAM indices coincide.
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic          full_q,  full_d;
  logic          empty_q, empty_d;
  logic          af_q,    af_d;
  logic          ovf_q,   ovf_d;
  logic          udf_q,   udf_d;

  // Accepts look only at the registered flags, so a simultaneous pop never
  // frees space for a push in the same cycle (and vice versa).
  assign wr_accept = wr_en & ~full_q;
  assign rd_accept = rd_en & ~empty_q;

  // Next pointers, flags and pulses; flush clears everything and suppresses pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      ovf_d = wr_en & full_q;
      udf_d = rd_en & empty_q;
    end

    // Flags come from the next pointers so they land on the same edge.
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    count_d = wr_ptr_d - rd_ptr_d;
    af_d    = (count_d >= AF_THRESH);
  end

  bin_to_gray_n #(
    .N (PW)
  ) u_wr_gray (
    .bin  (wr_ptr_d),
    .gray (wr_gray_d)
  );

  bin_to_gray_n #(
    .N (PW)
  ) u_rd_gray (
    .bin  (rd_ptr_d),
    .gray (rd_gray_d)
  );

  // State register; reset wins over flush and any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_gray_q <= '0;
      rd_gray_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign wr_addr     = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr     = rd_ptr_q[ADDR_W-1:0];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign wr_ptr_gray = wr_gray_q;
  assign rd_ptr_gray = rd_gray_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_uart_fifo_ptr_ctrl.sv
// Directed bench for uart_fifo_ptr_ctrl with default sizing (depth 16, almost_full at 12).
// Latency: each step drives one cycle of requests and checks the registered results after the edge.
// Backpressure: expected accepts and pulses derive from a small pointer scoreboard.
module tb_uart_fifo_ptr_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;
  logic       wr_accept;
  logic       rd_accept;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  // Scoreboard pointers (5-bit, wrap bit included).
  logic [4:0] m_wr;
  logic [4:0] m_rd;
  logic [4:0] prev_wg;
  logic [4:0] prev_rg;

  uart_fifo_ptr_ctrl #(
    .ADDR_W   (4),
    .AF_LEVEL (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .wr_accept   (wr_accept),
    .rd_accept   (rd_accept),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock of stimulus: inputs applied 1 time unit after an edge,
  // combinational accepts checked before the next edge, registered state after it.
  task automatic step(input logic w, input logic r, input logic f, input logic rs);
    logic [4:0] cnt;
    logic       e_wacc, e_racc, e_ovf, e_udf;
    cnt    = m_wr - m_rd;
    e_wacc = w & (cnt != 5'd16);
    e_racc = r & (cnt != 5'd0);
    e_ovf  = w & (cnt == 5'd16) & ~f & ~rs;
    e_udf  = r & (cnt == 5'd0) & ~f & ~rs;
    wr_en = w; rd_en = r; flush = f; rst = rs;
    #1;
    chk("wr_accept", 32'(wr_accept), 32'(e_wacc));
    chk("rd_accept", 32'(rd_accept), 32'(e_racc));
    if (f | rs) begin
      m_wr = '0;
      m_rd = '0;
    end else begin
      if (e_wacc) m_wr = m_wr + 5'd1;
      if (e_racc) m_rd = m_rd + 5'd1;
    end
    prev_wg = wr_ptr_gray;
    prev_rg = rd_ptr_gray;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    cnt = m_wr - m_rd;
    chk("count",       32'(count),       32'(cnt));
    chk("empty",       32'(empty),       32'(cnt == 5'd0));
    chk("full",        32'(full),        32'(cnt == 5'd16));
    chk("almost_full", 32'(almost_full), 32'(cnt >= 5'd12));
    chk("wr_addr",     32'(wr_addr),     32'(m_wr[3:0]));
    chk("rd_addr",     32'(rd_addr),     32'(m_rd[3:0]));
    chk("wr_gray",     32'(wr_ptr_gray), 32'(gray5(m_wr)));
    chk("rd_gray",     32'(rd_ptr_gray), 32'(gray5(m_rd)));
    chk("overflow",    32'(overflow),    32'(e_ovf));
    chk("underflow",   32'(underflow),   32'(e_udf));
    if (!(f | rs)) begin
      chk("wr_gray_1bit", 32'($countones(prev_wg ^ wr_ptr_gray) <= 1), 32'd1);
      chk("rd_gray_1bit", 32'($countones(prev_rg ^ rd_ptr_gray) <= 1), 32'd1);
    end
  endtask

  initial begin
    logic [3:0] sv_wa;
    logic [3:0] sv_ra;
    m_wr = '0; m_rd = '0; prev_wg = '0; prev_rg = '0;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // Reset held for two edges, then idle state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_empty",  32'(empty),       32'd1);
    chk("rst_full",   32'(full),        32'd0);
    chk("rst_count",  32'(count),       32'd0);
    chk("rst_af",     32'(almost_full), 32'd0);
    chk("rst_wgray",  32'(wr_ptr_gray), 32'd0);
    chk("rst_rgray",  32'(rd_ptr_gray), 32'd0);
    chk("rst_ovf",    32'(overflow),    32'd0);
    chk("rst_udf",    32'(underflow),   32'd0);
    step(0, 0, 0, 0);

    // Fill: count steps 1..16, almost_full from the 12th push.
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0);
      if (i == 11) chk("af_before_12", 32'(almost_full), 32'd0);
      if (i == 12) chk("af_at_12",     32'(almost_full), 32'd1);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);
    // 17th push: rejected, overflow pulse, then pulse clears.
    step(1, 0, 0, 0);
    chk("push17_ovf",   32'(overflow), 32'd1);
    chk("push17_count", 32'(count),    32'd16);
    step(0, 0, 0, 0);
    chk("ovf_clears", 32'(overflow), 32'd0);

    // Drain 16: wrap bit set on the read pointer, index back to 0.
    repeat (16) step(0, 1, 0, 0);
    chk("drain_empty",  32'(empty),       32'd1);
    chk("drain_raddr",  32'(rd_addr),     32'd0);
    chk("drain_rgray",  32'(rd_ptr_gray), 32'(5'b11000));
    step(0, 1, 0, 0);
    chk("pop17_udf", 32'(underflow), 32'd1);

    // Push+pop while empty: push wins, underflow reported.
    step(1, 1, 0, 0);
    chk("pp_empty_count", 32'(count),     32'd1);
    chk("pp_empty_udf",   32'(underflow), 32'd1);
    chk("pp_empty_empty", 32'(empty),     32'd0);

    // Push+pop at count 5: count holds, both addresses advance.
    repeat (4) step(1, 0, 0, 0);
    sv_wa = wr_addr;
    sv_ra = rd_addr;
    step(1, 1, 0, 0);
    chk("pp5_count", 32'(count),   32'd5);
    chk("pp5_waddr", 32'(wr_addr), 32'(sv_wa + 4'd1));
    chk("pp5_raddr", 32'(rd_addr), 32'(sv_ra + 4'd1));

    // Push+pop while full: pop wins, overflow reported.
    repeat (11) step(1, 0, 0, 0);
    chk("pre_full", 32'(full), 32'd1);
    step(1, 1, 0, 0);
    chk("pp_full_count", 32'(count),    32'd15);
    chk("pp_full_ovf",   32'(overflow), 32'd1);

    // Random traffic with per-cycle Gray and scoreboard checks.
    for (int i = 0; i < 64; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end

    // Flush at count 9 with both requests active.
    step(0, 0, 1, 0);
    repeat (9) step(1, 0, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd9);
    step(1, 1, 1, 0);
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_empty", 32'(empty),     32'd1);
    chk("flush_ovf",   32'(overflow),  32'd0);
    chk("flush_udf",   32'(underflow), 32'd0);

    // Same scenario using reset.
    repeat (9) step(1, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 32'd9);
    step(1, 1, 0, 1);
    chk("rst2_count", 32'(count),       32'd0);
    chk("rst2_empty", 32'(empty),       32'd1);
    chk("rst2_wgray", 32'(wr_ptr_gray), 32'd0);
    chk("rst2_ovf",   32'(overflow),    32'd0);
    chk("rst2_udf",   32'(underflow),   32'd0);

    // Rst together with flush still lands in the reset state.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_flush_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
